hwpe_ctrl_periph_adapter: RTL and testbench

HWPE_CTRL_PERIPH_ADAPTER -- requirements
Module: hwpe_ctrl_periph_adapter

---
 rtl/hwpe_ctrl_periph_adapter.sv | 133 +++++++++++++
 tb/tb_hwpe_ctrl_periph_adapter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_periph_adapter.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_periph_adapter
// Purpose  : Peripheral slave front-end of an HWPE: TRIGGER/STATUS handled
//            locally, other words forwarded to the register file.
// Revision : 1.0
// ============================================================================
module hwpe_ctrl_periph_adapter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  localparam int NUM_BYTE  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  periph_req,
  output logic                  periph_gnt,
  input  logic [31:0]           periph_add,
  input  logic                  periph_wen,
  input  logic [NUM_BYTE-1:0]   periph_be,
  input  logic [DATA_WIDTH-1:0] periph_data,
  input  logic [ID_WIDTH-1:0]   periph_id,
  output logic                  periph_r_valid,
  output logic [DATA_WIDTH-1:0] periph_r_data,
  output logic [ID_WIDTH-1:0]   periph_r_id,
  output logic                  rf_read_enable,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [NUM_BYTE-1:0]   rf_write_be,
  output logic                  trigger,
  input  logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] c_W_TRIGGER = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_W_STATUS  = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_trigger;
  logic                  r_r_valid;
  logic [ID_WIDTH-1:0]   r_r_id;
  logic                  r_fwd_read;
  logic [DATA_WIDTH-1:0] r_local_data;

  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_is_trigger;
  logic                  w_is_status;
  logic                  w_is_local;
  logic                  w_stall;
  logic                  w_gnt;
  logic                  w_gnt_read;
  logic                  w_gnt_write;
  logic                  w_start;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_local_data;

  // Address bits outside the word index alias and are deliberately dropped.
  logic w_unused_add;
  assign w_unused_add = ^{periph_add[31:ADDR_WIDTH+2], periph_add[1:0]};

  assign w_word       = periph_add[ADDR_WIDTH+1:2];
  assign w_is_trigger = (w_word == c_W_TRIGGER);
  assign w_is_status  = (w_word == c_W_STATUS);
  assign w_is_local   = w_is_trigger | w_is_status;
  assign w_busy       = (r_state == ST_RUNNING);

  // Grant depends only on the registered state, never on this cycle's done.
  assign w_stall     = w_busy && !periph_wen;
  assign w_gnt       = periph_req && !w_stall && !clear && !rst;
  assign w_gnt_read  = w_gnt && periph_wen;
  assign w_gnt_write = w_gnt && !periph_wen;
  assign w_start     = w_gnt_write && w_is_trigger;

  assign periph_gnt      = w_gnt;
  assign rf_read_enable  = w_gnt_read && !w_is_local;
  assign rf_read_addr    = w_word;
  assign rf_write_enable = w_gnt_write && !w_is_local;
  assign rf_write_addr   = w_word;
  assign rf_write_data   = periph_data;
  assign rf_write_be     = periph_be;

  assign w_local_data = (w_gnt_read && w_is_status)
                      ? {{(DATA_WIDTH-1){1'b0}}, w_busy}
                      : '0;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_next = ST_RUNNING;
      ST_RUNNING: if (done)    w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
    if (clear) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_trigger    <= 1'b0;
      r_r_valid    <= 1'b0;
      r_r_id       <= '0;
      r_fwd_read   <= 1'b0;
      r_local_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_trigger <= w_start;
      r_r_valid <= w_gnt;
      if (w_gnt) begin
        r_r_id       <= periph_id;
        r_fwd_read   <= w_gnt_read && !w_is_local;
        r_local_data <= w_local_data;
      end
    end
  end

  // The regfile returns read data one cycle after the address, aligned with r_valid.
  assign periph_r_valid = r_r_valid;
  assign periph_r_id    = r_r_id;
  assign periph_r_data  = r_fwd_read ? rf_read_data : r_local_data;
  assign trigger        = r_trigger;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_periph_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpe_ctrl_periph_adapter
// Purpose  : Self-checking bench with a behavioural model of the adapter.
// Revision : 1.0
// ============================================================================
module tb_hwpe_ctrl_periph_adapter;

  logic        clk = 1'b0;
  logic        rst, clear, done;
  logic        periph_req, periph_gnt, periph_wen;
  logic [31:0] periph_add, periph_data;
  logic [3:0]  periph_be;
  logic [7:0]  periph_id;
  logic        periph_r_valid;
  logic [31:0] periph_r_data;
  logic [7:0]  periph_r_id;
  logic        rf_read_enable, rf_write_enable;
  logic [4:0]  rf_read_addr, rf_write_addr;
  logic [31:0] rf_read_data, rf_write_data;
  logic [3:0]  rf_write_be;
  logic        trigger;

  always #5 clk = ~clk;

  hwpe_ctrl_periph_adapter #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .ID_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add),
    .periph_wen(periph_wen), .periph_be(periph_be), .periph_data(periph_data),
    .periph_id(periph_id),
    .periph_r_valid(periph_r_valid), .periph_r_data(periph_r_data), .periph_r_id(periph_r_id),
    .rf_read_enable(rf_read_enable), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_write_be(rf_write_be),
    .trigger(trigger), .done(done)
  );

  // Environment register file: registered address, data one cycle later.
  logic        mem_clr;
  logic [31:0] env_mem [32];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= '0;
    end else if (rf_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (rf_write_be[b]) env_mem[rf_write_addr][8*b +: 8] <= rf_write_data[8*b +: 8];
    end
    if (rf_read_enable) rf_read_data <= env_mem[rf_read_addr];
  end

  // Reference model state.
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [32];
  logic        busy      = 1'b0;
  logic        exp_rv    = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [7:0]  exp_rid   = '0;
  logic        exp_trig  = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs, check at the falling edge, advance the model.
  task automatic apply(input logic req, input logic wen, input logic [31:0] add,
                       input logic [3:0] be, input logic [31:0] data, input logic [7:0] id,
                       input logic dn, input logic clr, input logic rs);
    logic [4:0] w;
    logic       eg;
    periph_req = req; periph_wen = wen; periph_add = add; periph_be = be;
    periph_data = data; periph_id = id; done = dn; clear = clr; rst = rs;
    @(negedge clk);
    chk("r_valid", periph_r_valid, exp_rv);
    if (exp_rv) begin
      chk("r_data", periph_r_data, exp_rdata);
      chk("r_id", periph_r_id, exp_rid);
    end
    chk("trigger", trigger, exp_trig);
    w  = add[6:2];
    eg = req && !rs && !clr && !(busy && !wen);
    chk("gnt", periph_gnt, eg);
    chk("rf_we", rf_write_enable, eg && !wen && w >= 2);
    chk("rf_re", rf_read_enable, eg && wen && w >= 2);
    if (eg && w >= 2) begin
      chk("rf_addr", wen ? rf_read_addr : rf_write_addr, w);
      if (!wen) begin
        chk("rf_wdata", rf_write_data, data);
        chk("rf_be", rf_write_be, be);
      end
    end
    exp_rv    = eg;
    exp_rid   = id;
    exp_rdata = !wen ? 32'h0 : (w == 0) ? 32'h0 : (w == 1) ? {31'h0, busy} : ref_mem[w];
    exp_trig  = eg && !wen && w == 0;
    if (eg && !wen && w >= 2)
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    if (rs || clr) busy = 1'b0;
    else if (busy) begin
      if (dn) busy = 1'b0;
    end else if (eg && !wen && w == 0) busy = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] w, input logic [7:0] id);
    apply(1'b1, 1'b1, {25'h0, w, 2'b00}, 4'hF, 32'h0, id, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic wr(input logic [4:0] w, input logic [31:0] d, input logic [3:0] be, input logic [7:0] id);
    apply(1'b1, 1'b0, {25'h0, w, 2'b00}, be, d, id, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic idle_apply(input logic dn);
    apply(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 8'h0, dn, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        req;
    logic        wen;
    logic [31:0] add;
    logic        gnt;
    logic        re;
    logic        we;
    logic [4:0]  a;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int stalls;
    logic [31:0] r;
    logic [4:0]  rw;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 5'd2};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 5'd3};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0094, 1'b1, 1'b0, 1'b1, 5'd5};
    tbl[7] = '{1'b1, 1'b1, 32'hFFFF_FF7C, 1'b1, 1'b1, 1'b0, 5'd31};

    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    mem_clr = 1'b1; rst = 1'b1; clear = 1'b0; done = 1'b0;
    periph_req = 1'b0; periph_wen = 1'b1; periph_add = '0; periph_be = '0;
    periph_data = '0; periph_id = '0;
    tick(); tick(); tick();
    mem_clr = 1'b0;

    // Reset state: request during reset is not granted, outputs are zero after.
    apply(1'b1, 1'b1, 32'h8, 4'hF, 32'h0, 8'hAA, 1'b0, 1'b0, 1'b1);
    tick();
    idle_apply(1'b0);
    chk("rst_r_data", periph_r_data, 32'h0);
    chk("rst_r_id", periph_r_id, 32'h0);
    tick();

    // Decode table, all in IDLE.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].req, tbl[i].wen, tbl[i].add, 4'hF, $urandom, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("tbl_gnt", periph_gnt, tbl[i].gnt);
      chk("tbl_re", rf_read_enable, tbl[i].re);
      chk("tbl_we", rf_write_enable, tbl[i].we);
      if (tbl[i].re) chk("tbl_raddr", rf_read_addr, tbl[i].a);
      if (tbl[i].we) chk("tbl_waddr", rf_write_addr, tbl[i].a);
      tick();
    end

    // Write then read word 3.
    wr(5'd3, 32'hDEADBEEF, 4'hF, 8'h01);
    rd(5'd3, 8'h5A);
    idle_apply(1'b0);
    chk("ex_rw_valid", periph_r_valid, 32'h1);
    chk("ex_rw_data", periph_r_data, 32'hDEADBEEF);
    chk("ex_rw_id", periph_r_id, 32'h5A);
    tick();

    // Trigger pulse and STATUS while running / after done.
    wr(5'd0, 32'h0, 4'hF, 8'h02);
    apply(1'b1, 1'b1, 32'h4, 4'hF, 32'h0, 8'h03, 1'b0, 1'b0, 1'b0);
    chk("ex_trig_pulse", trigger, 32'h1);
    tick();
    idle_apply(1'b0);
    chk("ex_status_busy", periph_r_data, 32'h1);
    chk("ex_trig_once", trigger, 32'h0);
    tick();
    idle_apply(1'b1);
    tick();
    rd(5'd1, 8'h04);
    idle_apply(1'b0);
    chk("ex_status_idle", periph_r_data, 32'h0);
    tick();

    // Write stalled while running, released the cycle after done.
    wr(5'd0, 32'h0, 4'hF, 8'h05);
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 32'h10, 4'hF, 32'hCAFE0004, 8'h06, k == 2, 1'b0, 1'b0);
      if (!periph_gnt) stalls++;
      tick();
    end
    chk("ex_stall_cycles", stalls, 32'd3);
    idle_apply(1'b0);
    chk("ex_stall_rvalid", periph_r_valid, 32'h1);
    tick();

    // Back-to-back reads of words 2..5.
    for (int k = 2; k < 6; k++) wr(5'(k), 32'h1000_0000 + k, 4'hF, 8'h00);
    for (int k = 2; k < 6; k++) rd(5'(k), 8'h20 + 8'(k));
    idle_apply(1'b0);
    chk("ex_b2b_last_id", periph_r_id, 32'h25);
    chk("ex_b2b_last_data", periph_r_data, 32'h1000_0005);
    tick();

    // Partial byte-enable write.
    wr(5'd6, 32'h0, 4'hF, 8'h00);
    wr(5'd6, 32'h11223344, 4'h3, 8'h00);
    rd(5'd6, 8'h07);
    idle_apply(1'b0);
    chk("ex_be_data", periph_r_data, 32'h0000_3344);
    tick();

    // Reset while running with a request outstanding.
    wr(5'd0, 32'h0, 4'hF, 8'h08);
    apply(1'b1, 1'b1, 32'h4, 4'hF, 32'h0, 8'h09, 1'b0, 1'b0, 1'b1);
    tick();
    idle_apply(1'b0);
    chk("ex_rst_no_valid", periph_r_valid, 32'h0);
    chk("ex_rst_no_trig", trigger, 32'h0);
    tick();
    rd(5'd1, 8'h0A);
    idle_apply(1'b0);
    chk("ex_rst_status", periph_r_data, 32'h0);
    tick();

    // Clear while running.
    wr(5'd0, 32'h0, 4'hF, 8'h0B);
    apply(1'b1, 1'b1, 32'h8, 4'hF, 32'h0, 8'h0C, 1'b0, 1'b1, 1'b0);
    tick();
    rd(5'd1, 8'h0D);
    idle_apply(1'b0);
    chk("ex_clr_status", periph_r_data, 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      r  = $urandom;
      rw = 5'($urandom_range(0, 7));
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, {r[31:7], rw, r[1:0]},
            4'($urandom), $urandom, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
